hash_generator: RTL and testbench

- Keystream source for the stream cipher.
- Holds a 32-bit Galois LFSR that is seeded byte-by-byte from the data router. On each request pulse from the encryption block it produces one 8-bit hash byte.
- It publishes its state on hash_generator_state. The encryption block reads this to decide when it may issue a request.

---
 rtl/hash_generator.sv | 103 ++++++++++
 tb/tb_hash_generator.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_generator.sv
// Keystream source for the stream cipher. A 32-bit Galois LFSR is seeded one
// byte at a time. Each request produces one 8-bit hash byte from 8 LFSR steps.

package types_pkg;
  typedef enum logic [1:0] {
    GROUND,
    SEEDING,
    READY,
    GENERATING
  } hash_generator_state_t;
endpackage

module hash_generator #(
  parameter logic [31:0] TAPS       = 32'h80200003,
  parameter logic [31:0] RESET_SEED = 32'hACE12468
) (
  input  logic                                clk,
  input  logic                                nrst,
  input  logic [7:0]                          seed_byte_in,
  input  logic                                seed_byte_pulse,
  input  logic                                request_byte_pulse,
  output logic [7:0]                          hash_byte,
  output logic                                hash_byte_pulse,
  output types_pkg::hash_generator_state_t    hash_generator_state
);

  import types_pkg::*;

  hash_generator_state_t state_q;
  logic [31:0]           lfsr_q;
  logic [7:0]            shreg_q;
  logic [7:0]            hash_byte_q;
  logic                  pulse_q;
  logic [3:0]            bit_count_q;
  logic [1:0]            seed_count_q;

  logic [31:0]           lfsr_stepped;
  logic [31:0]           seed_shifted;

  // One Galois step and the seed-byte shift, shared by the FSM below.
  always_comb begin
    lfsr_stepped = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : 32'h0);
    seed_shifted = {lfsr_q[23:0], seed_byte_in};
  end

  // Control FSM; owns the LFSR and all registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= GROUND;
      lfsr_q       <= RESET_SEED;
      shreg_q      <= 8'h00;
      hash_byte_q  <= 8'h00;
      pulse_q      <= 1'b0;
      bit_count_q  <= 4'd0;
      seed_count_q <= 2'd0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        GROUND, READY: begin
          // Seed has priority; a simultaneous request is dropped.
          if (seed_byte_pulse) begin
            lfsr_q       <= seed_shifted;
            seed_count_q <= 2'd1;
            state_q      <= SEEDING;
          end else if (request_byte_pulse) begin
            bit_count_q <= 4'd0;
            state_q     <= GENERATING;
          end
        end
        SEEDING: begin
          if (seed_byte_pulse) begin
            seed_count_q <= seed_count_q + 2'd1;
            if (seed_count_q == 2'd3) begin
              // An all-zero seed would lock the LFSR; fall back to the reset seed.
              lfsr_q  <= (seed_shifted == 32'h0) ? RESET_SEED : seed_shifted;
              state_q <= GROUND;
            end else begin
              lfsr_q <= seed_shifted;
            end
          end
        end
        GENERATING: begin
          if (bit_count_q != 4'd8) begin
            // First out bit ends up in bit 0 after eight shifts.
            lfsr_q      <= lfsr_stepped;
            shreg_q     <= {lfsr_q[0], shreg_q[7:1]};
            bit_count_q <= bit_count_q + 4'd1;
          end else begin
            hash_byte_q <= shreg_q;
            pulse_q     <= 1'b1;
            state_q     <= READY;
          end
        end
        default: state_q <= GROUND;
      endcase
    end
  end

  assign hash_byte            = hash_byte_q;
  assign hash_byte_pulse      = pulse_q;
  assign hash_generator_state = state_q;

endmodule

// File: tb/tb_hash_generator.sv
// Self-checking bench for hash_generator: reset, seeding, generation latency,
// ignored pulses, reset abort and back-to-back request throughput.

module tb_hash_generator;
  import types_pkg::*;

  localparam logic [31:0] TAPS       = 32'h80200003;
  localparam logic [31:0] RESET_SEED = 32'hACE12468;

  logic                  clk = 1'b0;
  logic                  nrst = 1'b0;
  logic [7:0]            seed_byte_in = 8'h00;
  logic                  seed_byte_pulse = 1'b0;
  logic                  request_byte_pulse = 1'b0;
  logic [7:0]            hash_byte;
  logic                  hash_byte_pulse;
  hash_generator_state_t hash_generator_state;

  hash_generator #(
    .TAPS       (TAPS),
    .RESET_SEED (RESET_SEED)
  ) dut (
    .clk                  (clk),
    .nrst                 (nrst),
    .seed_byte_in         (seed_byte_in),
    .seed_byte_pulse      (seed_byte_pulse),
    .request_byte_pulse   (request_byte_pulse),
    .hash_byte            (hash_byte),
    .hash_byte_pulse      (hash_byte_pulse),
    .hash_generator_state (hash_generator_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: current LFSR word and the bytes of a seed in progress.
  logic [31:0] m_lfsr;
  logic [7:0]  seed_q[$];

  typedef struct {
    logic [31:0] seed;
    logic [31:0] exp_seeded;
    logic [7:0]  exp_byte;
    logic [31:0] exp_lfsr;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Eight keystream steps from word s; returns {byte, next word}.
  function automatic logic [39:0] ref_gen(input logic [31:0] s);
    logic [7:0] b;
    logic       o;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      o    = s[0];
      b[i] = o;
      s    = (s >> 1) ^ (o ? TAPS : 32'h0);
    end
    return {b, s};
  endfunction

  task automatic idle_no_pulse(input int n, input string name);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (hash_byte_pulse) seen++;
    end
    chk(name, seen, 0);
  endtask

  task automatic send_seed(input logic [7:0] b);
    logic [31:0] w;
    @(negedge clk);
    seed_byte_in    = b;
    seed_byte_pulse = 1'b1;
    @(negedge clk);
    seed_byte_pulse = 1'b0;
    seed_q.push_back(b);
    chk("seed_no_pulse", hash_byte_pulse, 1'b0);
    if (seed_q.size() == 4) begin
      w = {seed_q[0], seed_q[1], seed_q[2], seed_q[3]};
      m_lfsr = (w == 32'h0) ? RESET_SEED : w;
      seed_q.delete();
      chk("seed_done_state", hash_generator_state, GROUND);
      chk("seed_done_lfsr", dut.lfsr_q, m_lfsr);
    end else begin
      chk("seeding_state", hash_generator_state, SEEDING);
    end
  endtask

  // Issue one request; optionally inject stray pulses while generating.
  task automatic do_request(input bit inject);
    logic [39:0] r;
    logic [7:0]  held;
    int          k_seen;
    r      = ref_gen(m_lfsr);
    k_seen = -1;
    @(negedge clk);
    request_byte_pulse = 1'b1;
    @(posedge clk); #1;
    request_byte_pulse = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (inject && k < 8) begin
        seed_byte_pulse    = 1'($urandom_range(0, 1));
        seed_byte_in       = 8'($urandom);
        request_byte_pulse = 1'($urandom_range(0, 1));
      end else begin
        seed_byte_pulse    = 1'b0;
        request_byte_pulse = 1'b0;
      end
      @(posedge clk); #1;
      if (hash_byte_pulse) begin
        k_seen = k;
        break;
      end
    end
    seed_byte_pulse    = 1'b0;
    request_byte_pulse = 1'b0;
    chk("req_latency", k_seen, 9);
    chk("req_byte", hash_byte, r[39:32]);
    chk("req_state_ready", hash_generator_state, READY);
    m_lfsr = r[31:0];
    chk("req_lfsr", dut.lfsr_q, m_lfsr);
    held = hash_byte;
    @(posedge clk); #1;
    chk("pulse_one_cycle", hash_byte_pulse, 1'b0);
    chk("byte_held", hash_byte, held);
  endtask

  initial begin
    logic [39:0] r_reset;
    logic [39:0] r;
    logic [7:0]  last_byte;
    int          last_pulse;
    int          npulse;

    // Reset state while nrst is held low.
    #12;
    chk("rst_state", hash_generator_state, GROUND);
    chk("rst_byte", hash_byte, 8'h00);
    chk("rst_pulse", hash_byte_pulse, 1'b0);
    chk("rst_lfsr", dut.lfsr_q, RESET_SEED);
    @(negedge clk);
    nrst   = 1'b1;
    m_lfsr = RESET_SEED;

    r_reset = ref_gen(RESET_SEED);
    do_request(1'b0);

    tbl[0] = '{32'h00000001, 32'h00000001, 8'hDB, 32'hDB36C002};
    tbl[1] = '{32'h00000000, RESET_SEED, r_reset[39:32], r_reset[31:0]};
    r = ref_gen(32'h12345678);
    tbl[2] = '{32'h12345678, 32'h12345678, r[39:32], r[31:0]};
    r = ref_gen(32'hFFFFFFFF);
    tbl[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, r[39:32], r[31:0]};

    for (int t = 0; t < 4; t++) begin
      for (int b = 3; b >= 0; b--) send_seed(8'(tbl[t].seed >> (8 * b)));
      chk("tbl_seeded", dut.lfsr_q, tbl[t].exp_seeded);
      do_request(1'b0);
      chk("tbl_byte", hash_byte, 32'(tbl[t].exp_byte));
      chk("tbl_lfsr", dut.lfsr_q, tbl[t].exp_lfsr);
    end

    // Stray seed and request pulses during generation are ignored.
    do_request(1'b1);
    idle_no_pulse(12, "inject_no_second_pulse");

    // Reset mid-generation abandons the byte.
    @(negedge clk);
    request_byte_pulse = 1'b1;
    @(posedge clk); #1;
    request_byte_pulse = 1'b0;
    repeat (4) @(posedge clk);
    #2 nrst = 1'b0;
    #1;
    chk("abort_state", hash_generator_state, GROUND);
    chk("abort_pulse", hash_byte_pulse, 1'b0);
    chk("abort_byte", hash_byte, 8'h00);
    chk("abort_lfsr", dut.lfsr_q, RESET_SEED);
    @(negedge clk);
    nrst   = 1'b1;
    m_lfsr = RESET_SEED;
    seed_q.delete();
    idle_no_pulse(12, "abort_no_pulse");
    do_request(1'b0);

    // Simultaneous seed and request while READY: seed wins.
    @(negedge clk);
    seed_byte_in       = 8'h5A;
    seed_byte_pulse    = 1'b1;
    request_byte_pulse = 1'b1;
    @(negedge clk);
    seed_byte_pulse    = 1'b0;
    request_byte_pulse = 1'b0;
    seed_q.push_back(8'h5A);
    chk("simul_state", hash_generator_state, SEEDING);
    idle_no_pulse(12, "simul_no_pulse");
    send_seed(8'h01);
    send_seed(8'h02);
    send_seed(8'h03);

    // Partial seed: requests are ignored while SEEDING.
    send_seed(8'hC3);
    send_seed(8'h3C);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      request_byte_pulse = 1'b1;
      @(negedge clk);
      request_byte_pulse = 1'b0;
      chk("partial_state", hash_generator_state, SEEDING);
      idle_no_pulse(12, "partial_no_pulse");
    end
    send_seed(8'h96);
    send_seed(8'h69);

    // Request held high: pulses exactly 10 cycles apart, byte stable between.
    @(negedge clk);
    request_byte_pulse = 1'b1;
    last_pulse = -1;
    last_byte  = hash_byte;
    npulse     = 0;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk); #1;
      if (hash_byte_pulse) begin
        npulse++;
        r = ref_gen(m_lfsr);
        chk("cont_byte", hash_byte, r[39:32]);
        m_lfsr = r[31:0];
        if (last_pulse >= 0) chk("cont_gap", c - last_pulse, 10);
        last_pulse = c;
        last_byte  = hash_byte;
      end else begin
        chk("cont_stable", hash_byte, last_byte);
      end
    end
    request_byte_pulse = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (hash_byte_pulse) begin
        npulse++;
        r = ref_gen(m_lfsr);
        chk("drain_byte", hash_byte, r[39:32]);
        m_lfsr = r[31:0];
      end
    end
    chk("cont_npulse_ok", npulse >= 4, 1);
    chk("cont_lfsr", dut.lfsr_q, m_lfsr);

    // Randomized mix of seeds and requests against the model.
    for (int it = 0; it < 16; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        bit zero_seed;
        zero_seed = ($urandom_range(0, 3) == 0);
        for (int b = 0; b < 4; b++) begin
          send_seed(zero_seed ? 8'h00 : 8'($urandom));
          if (b < 3 && $urandom_range(0, 1) == 1) begin
            @(negedge clk);
            request_byte_pulse = 1'b1;
            @(negedge clk);
            request_byte_pulse = 1'b0;
            chk("rnd_seed_ignore_req", hash_generator_state, SEEDING);
          end
        end
      end else begin
        do_request(1'($urandom_range(0, 1)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
